// File: rtl/lm32_trace_buffer.sv
// LM32 instruction-retire trace buffer.
// Circular capture of {ts, pc, instr} with pre/post-trigger stop.
module lm32_trace_buffer #(
    parameter int DEPTH    = 64,
    parameter int PC_WIDTH = 30,
    parameter int TS_WIDTH = 16,
    localparam int AW      = $clog2(DEPTH),
    localparam int EW      = TS_WIDTH + PC_WIDTH + 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                stall_x,
    input  logic                stall_m,
    input  logic                valid_w,
    input  logic                kill_w,
    input  logic [31:0]         instruction_d,
    input  logic [PC_WIDTH-1:0] pc_w,
    input  logic                arm_i,
    input  logic                trig_pc_en_i,
    input  logic [PC_WIDTH-1:0] trig_pc_i,
    input  logic                trig_op_en_i,
    input  logic [5:0]          trig_op_i,
    input  logic                trig_ext_i,
    input  logic [AW:0]         post_count_i,
    input  logic [AW-1:0]       rd_addr_i,
    output logic [EW-1:0]       rd_data_o,
    output logic [1:0]          state_o,
    output logic                triggered_o,
    output logic                done_o,
    output logic [AW-1:0]       wr_ptr_o,
    output logic [AW:0]         count_o,
    output logic [AW-1:0]       oldest_o,
    output logic [AW-1:0]       trig_index_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [31:0]          instr_x;
    logic [31:0]          instr_m;
    logic [31:0]          instr_w;
    logic [TS_WIDTH-1:0]  ts;
    logic [AW:0]          rem;
    logic [EW-1:0]        mem [DEPTH];
    logic                 ret;
    logic                 capturing;
    logic                 we;
    logic                 hit;

    assign ret       = valid_w && !kill_w;
    assign capturing = (state == S_ARMED) || (state == S_POST);
    assign we        = ret && capturing && !arm_i;
    assign hit       = (state == S_ARMED) && (
                           (ret && trig_pc_en_i && (pc_w == trig_pc_i)) ||
                           (ret && trig_op_en_i && (instr_w[31:26] == trig_op_i)) ||
                           trig_ext_i);

    // Follow the instruction word from decode down to writeback.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_x <= '0;
            instr_m <= '0;
            instr_w <= '0;
        end else begin
            if (!stall_x) instr_x <= instruction_d;
            if (!stall_m) instr_m <= instr_x;
            instr_w <= instr_m;
        end
    end

    // Capture state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next capture state; arm overrides everything but reset.
    always_comb begin
        state_nx = state;
        if (arm_i) begin
            state_nx = S_ARMED;
        end else begin
            unique case (state)
                S_IDLE:  state_nx = S_IDLE;
                S_ARMED: if (hit) state_nx = (post_count_i == '0) ? S_DONE : S_POST;
                S_POST:  if (ret && rem == (AW+1)'(1)) state_nx = S_DONE;
                S_DONE:  state_nx = S_DONE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // State-derived outputs.
    always_comb begin
        state_o = state;
        done_o  = (state == S_DONE);
    end

    // Write pointer, fill count, timestamp and trigger bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i || arm_i) begin
            wr_ptr_o     <= '0;
            count_o      <= '0;
            ts           <= '0;
            triggered_o  <= 1'b0;
            trig_index_o <= '0;
            rem          <= '0;
        end else begin
            if (capturing) ts <= ts + TS_WIDTH'(1);
            if (we) begin
                wr_ptr_o <= wr_ptr_o + AW'(1);
                if (!count_o[AW]) count_o <= count_o + (AW+1)'(1);
            end
            if (hit) begin
                triggered_o  <= 1'b1;
                rem          <= post_count_i;
                trig_index_o <= wr_ptr_o;
            end else if (state == S_POST && ret) begin
                rem <= rem - (AW+1)'(1);
            end
        end
    end

    assign oldest_o = count_o[AW] ? wr_ptr_o : '0;

    // Trace storage write port.
    always_ff @(posedge clk_i) begin
        if (we) mem[wr_ptr_o] <= {ts, pc_w, instr_w};
    end

    // Registered read port; same-address write returns old data.
    always_ff @(posedge clk_i) begin
        if (rst_i) rd_data_o <= '0;
        else       rd_data_o <= mem[rd_addr_i];
    end

endmodule

// File: tb/tb_lm32_trace_buffer.sv
// Directed testbench for lm32_trace_buffer.
// DEPTH=8 configuration with hand-computed expectations.
module tb_lm32_trace_buffer;

    localparam int DEPTH = 8;
    localparam int PCW   = 30;
    localparam int TSW   = 16;
    localparam int AW    = 3;
    localparam int EW    = TSW + PCW + 32;

    logic           clk_i = 0;
    logic           rst_i = 1;
    logic           stall_x = 0;
    logic           stall_m = 0;
    logic           valid_w = 0;
    logic           kill_w = 0;
    logic [31:0]    instruction_d = 0;
    logic [PCW-1:0] pc_w = 0;
    logic           arm_i = 0;
    logic           trig_pc_en_i = 0;
    logic [PCW-1:0] trig_pc_i = 0;
    logic           trig_op_en_i = 0;
    logic [5:0]     trig_op_i = 0;
    logic           trig_ext_i = 0;
    logic [AW:0]    post_count_i = 0;
    logic [AW-1:0]  rd_addr_i = 0;
    logic [EW-1:0]  rd_data_o;
    logic [1:0]     state_o;
    logic           triggered_o;
    logic           done_o;
    logic [AW-1:0]  wr_ptr_o;
    logic [AW:0]    count_o;
    logic [AW-1:0]  oldest_o;
    logic [AW-1:0]  trig_index_o;

    int n_checks = 0;
    int n_fail   = 0;

    lm32_trace_buffer #(.DEPTH(DEPTH), .PC_WIDTH(PCW), .TS_WIDTH(TSW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_x(stall_x), .stall_m(stall_m),
        .valid_w(valid_w), .kill_w(kill_w), .instruction_d(instruction_d),
        .pc_w(pc_w), .arm_i(arm_i), .trig_pc_en_i(trig_pc_en_i),
        .trig_pc_i(trig_pc_i), .trig_op_en_i(trig_op_en_i),
        .trig_op_i(trig_op_i), .trig_ext_i(trig_ext_i),
        .post_count_i(post_count_i), .rd_addr_i(rd_addr_i),
        .rd_data_o(rd_data_o), .state_o(state_o), .triggered_o(triggered_o),
        .done_o(done_o), .wr_ptr_o(wr_ptr_o), .count_o(count_o),
        .oldest_o(oldest_o), .trig_index_o(trig_index_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic retire(input logic [PCW-1:0] pc);
        valid_w = 1;
        pc_w = pc;
        step();
        valid_w = 0;
    endtask

    task automatic arm();
        arm_i = 1;
        step();
        arm_i = 0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        rd_addr_i = a;
        step();
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_rd_data", rd_data_o, 0);
        check("rst_state", state_o, 0);
        check("rst_trig", triggered_o, 0);
        check("rst_done", done_o, 0);
        check("rst_trig_index", trig_index_o, 0);
        rst_i = 0;
        for (int i = 0; i < 5; i++) retire(PCW'(i));
        check("idle_state", state_o, 0);
        check("idle_count", count_o, 0);
        check("idle_wr_ptr", wr_ptr_o, 0);
        check("idle_oldest", oldest_o, 0);

        // Three retires, no trigger
        arm();
        check("arm_state", state_o, 1);
        retire(30'h100);
        retire(30'h101);
        retire(30'h102);
        check("fill3_count", count_o, 3);
        check("fill3_wr_ptr", wr_ptr_o, 3);
        check("fill3_oldest", oldest_o, 0);
        rd(1);
        check("fill3_rd_pc", rd_data_o[32 +: PCW], 30'h101);

        // Wrap with 11 retires
        arm();
        check("rearm_count", count_o, 0);
        for (int i = 0; i < 11; i++) retire(PCW'(30'h300 + i));
        check("wrap_count", count_o, 8);
        check("wrap_wr_ptr", wr_ptr_o, 3);
        check("wrap_oldest", oldest_o, 3);
        check("wrap_state", state_o, 1);
        rd(2);
        check("wrap_rd_pc", rd_data_o[32 +: PCW], 30'h30a);

        // PC trigger with two post retires
        trig_pc_en_i = 1;
        trig_pc_i = 30'h105;
        post_count_i = 2;
        arm();
        for (int i = 0; i < 5; i++) retire(PCW'(30'h100 + i));
        check("pc_pre_trig", triggered_o, 0);
        retire(30'h105);
        check("pc_trig_index", trig_index_o, 5);
        check("pc_state_post", state_o, 2);
        check("pc_triggered", triggered_o, 1);
        post_count_i = 0;
        retire(30'h106);
        check("pc_state_post2", state_o, 2);
        retire(30'h107);
        check("pc_state_done", state_o, 3);
        check("pc_done", done_o, 1);
        check("pc_count", count_o, 8);
        check("pc_wr_ptr", wr_ptr_o, 0);
        retire(30'h108);
        check("pc_after_count", count_o, 8);
        check("pc_after_wr_ptr", wr_ptr_o, 0);
        rd(0);
        check("pc_rd0", rd_data_o[32 +: PCW], 30'h100);
        rd(7);
        check("pc_rd7", rd_data_o[32 +: PCW], 30'h107);
        check("pc_trig_hold", trig_index_o, 5);
        trig_pc_en_i = 0;

        // Opcode trigger, post count zero
        trig_op_en_i = 1;
        trig_op_i = 6'h2e;
        post_count_i = 0;
        arm();
        instruction_d = 32'hB8221800;
        step();
        step();
        step();
        check("op_wait_state", state_o, 1);
        retire(30'h200);
        instruction_d = 0;
        check("op_state", state_o, 3);
        check("op_triggered", triggered_o, 1);
        check("op_count", count_o, 1);
        check("op_trig_index", trig_index_o, 0);
        rd(0);
        check("op_rd_instr", rd_data_o[31:0], 32'hB8221800);
        check("op_rd_pc", rd_data_o[32 +: PCW], 30'h200);
        check("op_rd_ts", rd_data_o[EW-1 -: TSW], 3);
        trig_op_en_i = 0;

        // Killed retire is not recorded
        arm();
        kill_w = 1;
        retire(30'h10);
        kill_w = 0;
        check("kill_count", count_o, 0);

        // Arm wins over a coincident retire
        retire(30'h11);
        check("pre_arm_count", count_o, 1);
        valid_w = 1;
        arm();
        valid_w = 0;
        check("arm_ret_count", count_o, 0);
        check("arm_ret_ptr", wr_ptr_o, 0);

        // Arm wins over a coincident trigger
        trig_ext_i = 1;
        arm();
        trig_ext_i = 0;
        check("arm_ext_state", state_o, 1);
        check("arm_ext_trig", triggered_o, 0);

        // External trigger without a retire
        for (int i = 0; i < 4; i++) retire(PCW'(30'h400 + i));
        post_count_i = 3;
        trig_ext_i = 1;
        step();
        trig_ext_i = 0;
        check("ext_trig_index", trig_index_o, 4);
        check("ext_state", state_o, 2);
        check("ext_wr_ptr", wr_ptr_o, 4);

        // Reset overrides arm mid-capture
        rst_i = 1;
        arm_i = 1;
        step();
        rst_i = 0;
        arm_i = 0;
        check("rst_arm_state", state_o, 0);
        check("rst_arm_trig", triggered_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
